peak_dpu_is0: RTL
=================

# peak_dpu_is0

Issue stage for instruction slot 0 of the DPU. It consumes decoded fields from the slot-0 decoder: source-register reads, destination write, immediate and unit/op control. It holds a 32-entry scoreboard of pending destination writes, reads operands from an internal 32x32 register file, and presents one operand-ready instruction per cycle to the execution units over a valid/ready handshake. Writebacks from the execution units update the register file and clear scoreboard entries.

## Interface
Parameters:
- XLEN, 32, data width of registers, immediate and writeback data
- CTL_W, 21, width of the opaque control bundle {is_ls, is_alu, is_mul, is_div, is_br, is_fp, is_csr, ls_op[2:0], alu_op[3:0], mul_op[1:0], div_op[1:0], br_op[2:0]}

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- de_vld  in  1  decoded instruction valid
- de_rdy  out  1  issue stage accepts the decoded instruction this cycle
- de_rd_r0_vld / de_rd_r1_vld / de_rd_r2_vld  in  1 each  source read enables
- de_rd_r0_addr / de_rd_r1_addr / de_rd_r2_addr  in  5 each  source register numbers
- de_wr_vld  in  1  destination write enable
- de_wr_addr  in  5  destination register
- de_imm  in  XLEN  immediate
- de_use_imm  in  1  immediate replaces source 1
- de_ctl  in  CTL_W  unit/op control bundle
- wb_vld  in  1  writeback valid
- wb_addr  in  5  writeback register
- wb_data  in  XLEN  writeback data
- is_vld  out  1  issued instruction valid
- is_rdy  in  1  execution units accept
- is_src0 / is_src1 / is_src2  out  XLEN each  operand values; is_src1 = imm when use_imm
- is_wr_vld  out  1  destination write enable
- is_wr_addr  out  5  destination register
- is_ctl  out  CTL_W  control bundle passed through

## Operation
- Single-entry issue register. Accept = de_vld & de_rdy.
- de_rdy = ~hazard & (~is_vld | is_rdy).
- hazard = any enabled source with addr≠0 whose scoreboard bit is set (RAW), or de_wr_vld with addr≠0 whose bit is set (WAW).
- On accept: capture operands, wr fields and ctl. Set is_vld. Set scoreboard[de_wr_addr] if de_wr_vld & addr≠0.
- Operands: register 0 reads as 0. A disabled source yields 0.
- If no accept and is_rdy is high, is_vld clears. If is_vld & ~is_rdy, all is_* outputs hold stable.
- Writeback: wb_vld & wb_addr≠0 writes the register file at the clock edge and clears scoreboard[wb_addr]. A writeback to an unset bit still writes the register file.
- Set and clear of the same bit in the same cycle: set wins.
- Reset: is_vld=0, is_src*=0, is_wr_vld=0, is_wr_addr=0, is_ctl=0, scoreboard all 0, de_rdy=0 while rst_n is low. Register file contents are not reset.
- Reset asserted mid-stall discards the held instruction and all pending bits.

## Timing
- de_rdy is combinational from de_* inputs, scoreboard, is_vld and is_rdy. is_* outputs are registered.
- Accept in cycle N gives is_vld high from cycle N+1.
- Back-to-back independent instructions issue at 1 per cycle while is_rdy stays high.
- RAW/WAW stall without bypass: wb in cycle N, accept in cycle N+1 with the new value.

## Configuration
- PEAK_DPU_IS_BYPASS_EN defined:
  - A same-cycle wb_vld to a scoreboarded register removes that register from the hazard check.
  - Matching sources take wb_data instead of the array value (0-cycle wb-to-accept).
  - WAW to the same register is also allowed; set wins.
- Not defined: the hazard check uses the registered scoreboard only.

## Structure
- peak_dpu_pkg holds XLEN, CTL_W, the control-bundle field offsets and the register-0 constant.
- Sub-module peak_dpu_rf: 32xXLEN array, one write port, three combinational read ports, x0 hardwired to 0. Bypass muxing stays in peak_dpu_is0.

## Test plan
- Reset, then de_vld=1, r0=x1, r1=x2, wr=x3 with x1=5, x2=7 preloaded via wb → cycle+1: is_vld=1, is_src0=5, is_src1=7, is_wr_addr=3, and scoreboard[3] set.
- Next instruction reads x3 → de_rdy=0 until wb x3=0x10 in cycle N. Accept in N+1 with is_src0=0x10. With the macro: accept in N with 0x10.
- is_rdy=0 for 3 cycles with is_vld=1 → all is_* stable and de_rdy=0. is_rdy=1 → the next instruction issues the following cycle.
- Source and destination x0 with use_imm=1, imm=0xFFFF_FFF0 → no stall, is_src0=0, is_src1=0xFFFF_FFF0, and the scoreboard is unchanged.
- WAW: x4 pending, new instruction writes x4 → stalled until wb x4. Same-cycle accept and wb x4 (macro on) → scoreboard[4] remains set.
- rst_n low during a stall with 3 pending bits → after release, is_vld=0 and the scoreboard is all 0, so a read of those registers is accepted immediately.

Source files
------------

// File: rtl/peak_dpu_pkg.sv
// Shared constants for the DPU slot-0 issue stage: data/control widths,
// control-bundle field offsets, register-file geometry and helpers.
package peak_dpu_pkg;

    localparam int XLEN   = 32;
    localparam int CTL_W  = 21;
    localparam int REG_AW = 5;
    localparam int NREG   = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    // Control bundle, MSB first:
    // {is_ls, is_alu, is_mul, is_div, is_br, is_fp, is_csr, ls_op, alu_op, mul_op, div_op, br_op}
    localparam int CTL_IS_LS      = 20;
    localparam int CTL_IS_ALU     = 19;
    localparam int CTL_IS_MUL     = 18;
    localparam int CTL_IS_DIV     = 17;
    localparam int CTL_IS_BR      = 16;
    localparam int CTL_IS_FP      = 15;
    localparam int CTL_IS_CSR     = 14;
    localparam int CTL_LS_OP_LSB  = 11;
    localparam int CTL_ALU_OP_LSB = 7;
    localparam int CTL_MUL_OP_LSB = 5;
    localparam int CTL_DIV_OP_LSB = 3;
    localparam int CTL_BR_OP_LSB  = 0;

    function automatic logic [NREG-1:0] reg_onehot(input logic [REG_AW-1:0] addr,
                                                   input logic              en);
        logic [NREG-1:0] vec;
        vec = {NREG{1'b0}};
        if (en) begin
            vec[addr] = 1'b1;
        end else begin
            vec = {NREG{1'b0}};
        end
        return vec;
    endfunction

    function automatic logic reg_is_nz(input logic [REG_AW-1:0] addr);
        return (addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/peak_dpu_rf.sv
// 32-entry register file for the slot-0 issue stage: one write port,
// three combinational read ports, x0 reads as zero and is never written.
module peak_dpu_rf #(
    parameter int W = peak_dpu_pkg::XLEN
) (
    input  logic         clk,
    input  logic         we,
    input  logic [4:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic [4:0]   raddr0,
    input  logic [4:0]   raddr1,
    input  logic [4:0]   raddr2,
    output logic [W-1:0] rdata0,
    output logic [W-1:0] rdata1,
    output logic [W-1:0] rdata2
);
    import peak_dpu_pkg::*;

    logic [W-1:0] mem_r [NREG];

    // Storage is intentionally not reset; x0 writes are dropped.
    always_ff @(posedge clk) begin
        if (we && reg_is_nz(waddr)) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata0 = reg_is_nz(raddr0) ? mem_r[raddr0] : {W{1'b0}};
    assign rdata1 = reg_is_nz(raddr1) ? mem_r[raddr1] : {W{1'b0}};
    assign rdata2 = reg_is_nz(raddr2) ? mem_r[raddr2] : {W{1'b0}};

endmodule

// File: rtl/peak_dpu_is0.sv
// Slot-0 issue stage: scoreboard, register-file read and a one-entry issue
// register. Optional writeback bypass is enabled by PEAK_DPU_IS_BYPASS_EN.
module peak_dpu_is0 #(
    parameter int XLEN  = peak_dpu_pkg::XLEN,
    parameter int CTL_W = peak_dpu_pkg::CTL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             de_vld,
    output logic             de_rdy,
    input  logic             de_rd_r0_vld,
    input  logic             de_rd_r1_vld,
    input  logic             de_rd_r2_vld,
    input  logic [4:0]       de_rd_r0_addr,
    input  logic [4:0]       de_rd_r1_addr,
    input  logic [4:0]       de_rd_r2_addr,
    input  logic             de_wr_vld,
    input  logic [4:0]       de_wr_addr,
    input  logic [XLEN-1:0]  de_imm,
    input  logic             de_use_imm,
    input  logic [CTL_W-1:0] de_ctl,
    input  logic             wb_vld,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic             is_vld,
    input  logic             is_rdy,
    output logic [XLEN-1:0]  is_src0,
    output logic [XLEN-1:0]  is_src1,
    output logic [XLEN-1:0]  is_src2,
    output logic             is_wr_vld,
    output logic [4:0]       is_wr_addr,
    output logic [CTL_W-1:0] is_ctl
);
    import peak_dpu_pkg::*;

    logic [NREG-1:0]  sb_r;
    logic [NREG-1:0]  sb_chk_s;
    logic [NREG-1:0]  wb_clr_s;
    logic [NREG-1:0]  de_set_s;
    logic             wb_en_s;
    logic             hazard_s;
    logic             de_rdy_s;
    logic             accept_s;
    logic             hit0_s, hit1_s, hit2_s;
    logic [XLEN-1:0]  rf_rd0_s, rf_rd1_s, rf_rd2_s;
    logic [XLEN-1:0]  src0_s, src1_s, src2_s;

    logic             is_vld_r;
    logic [XLEN-1:0]  is_src0_r, is_src1_r, is_src2_r;
    logic             is_wr_vld_r;
    logic [4:0]       is_wr_addr_r;
    logic [CTL_W-1:0] is_ctl_r;

    function automatic logic [XLEN-1:0] sel_src(input logic            en,
                                                input logic [XLEN-1:0] rf_data,
                                                input logic            byp_hit,
                                                input logic [XLEN-1:0] byp_data);
        logic [XLEN-1:0] val;
        if (!en) begin
            val = {XLEN{1'b0}};
        end else if (byp_hit) begin
            val = byp_data;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    peak_dpu_rf #(
        .W(XLEN)
    ) u_rf (
        .clk    (clk),
        .we     (wb_vld),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr0 (de_rd_r0_addr),
        .raddr1 (de_rd_r1_addr),
        .raddr2 (de_rd_r2_addr),
        .rdata0 (rf_rd0_s),
        .rdata1 (rf_rd1_s),
        .rdata2 (rf_rd2_s)
    );

    assign wb_en_s  = wb_vld & reg_is_nz(wb_addr);
    assign wb_clr_s = reg_onehot(wb_addr, wb_en_s);

`ifdef PEAK_DPU_IS_BYPASS_EN
    // A register being written back this cycle is no longer a hazard.
    assign sb_chk_s = sb_r & ~wb_clr_s;
    assign hit0_s   = wb_en_s & (wb_addr == de_rd_r0_addr);
    assign hit1_s   = wb_en_s & (wb_addr == de_rd_r1_addr);
    assign hit2_s   = wb_en_s & (wb_addr == de_rd_r2_addr);
`else
    assign sb_chk_s = sb_r;
    assign hit0_s   = 1'b0;
    assign hit1_s   = 1'b0;
    assign hit2_s   = 1'b0;
`endif

    assign hazard_s = (de_rd_r0_vld & reg_is_nz(de_rd_r0_addr) & sb_chk_s[de_rd_r0_addr])
                    | (de_rd_r1_vld & reg_is_nz(de_rd_r1_addr) & sb_chk_s[de_rd_r1_addr])
                    | (de_rd_r2_vld & reg_is_nz(de_rd_r2_addr) & sb_chk_s[de_rd_r2_addr])
                    | (de_wr_vld    & reg_is_nz(de_wr_addr)    & sb_chk_s[de_wr_addr]);

    // Held low through reset so nothing is offered to the decoder.
    assign de_rdy_s = rst_n & ~hazard_s & (~is_vld_r | is_rdy);
    assign accept_s = de_vld & de_rdy_s;
    assign de_rdy   = de_rdy_s;

    assign de_set_s = reg_onehot(de_wr_addr, accept_s & de_wr_vld & reg_is_nz(de_wr_addr));

    // Operand selection; the immediate overrides source 1.
    always_comb begin
        src0_s = sel_src(de_rd_r0_vld, rf_rd0_s, hit0_s, wb_data);
        src2_s = sel_src(de_rd_r2_vld, rf_rd2_s, hit2_s, wb_data);
        if (de_use_imm) begin
            src1_s = de_imm;
        end else begin
            src1_s = sel_src(de_rd_r1_vld, rf_rd1_s, hit1_s, wb_data);
        end
    end

    // Scoreboard: clear on writeback, set on accept; set wins on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_r <= {NREG{1'b0}};
        end else begin
            sb_r <= (sb_r & ~wb_clr_s) | de_set_s;
        end
    end

    // Single-entry issue register; holds while the execution units stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_vld_r     <= 1'b0;
            is_src0_r    <= {XLEN{1'b0}};
            is_src1_r    <= {XLEN{1'b0}};
            is_src2_r    <= {XLEN{1'b0}};
            is_wr_vld_r  <= 1'b0;
            is_wr_addr_r <= 5'd0;
            is_ctl_r     <= {CTL_W{1'b0}};
        end else if (accept_s) begin
            is_vld_r     <= 1'b1;
            is_src0_r    <= src0_s;
            is_src1_r    <= src1_s;
            is_src2_r    <= src2_s;
            is_wr_vld_r  <= de_wr_vld;
            is_wr_addr_r <= de_wr_addr;
            is_ctl_r     <= de_ctl;
        end else if (is_rdy) begin
            is_vld_r     <= 1'b0;
        end else begin
            is_vld_r     <= is_vld_r;
        end
    end

    assign is_vld     = is_vld_r;
    assign is_src0    = is_src0_r;
    assign is_src1    = is_src1_r;
    assign is_src2    = is_src2_r;
    assign is_wr_vld  = is_wr_vld_r;
    assign is_wr_addr = is_wr_addr_r;
    assign is_ctl     = is_ctl_r;

endmodule
